// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through transmit FIFO that sits in front of the UART core
// Ports:
//   clk, rst (async active-low)  clock and reset
//   flush                        synchronous clear of all stored entries
//   wr_dat, wr_en                bus-side write; no backpressure, drops when full
//   out_dat, out_vld, out_rdy    head entry handshake toward the UART core
//   level, af_thr, almost_full   occupancy, threshold and almost-full flag
//   full, empty                  occupancy flags
//   overflow, ovf_clr            sticky dropped-write flag and its clear
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int DAT_W = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [DAT_W-1:0]           wr_dat,
    input  logic                       wr_en,
    output logic [DAT_W-1:0]           out_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     level,
    input  logic [$clog2(DEPTH):0]     af_thr,
    output logic                       almost_full,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    logic [DAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             pop, push, drop;
    assign empty       = level == '0;
    assign full        = level == (AW+1)'(DEPTH);
    assign almost_full = level >= af_thr;
    assign out_vld     = !empty;
    assign out_dat     = mem[rd_ptr];
    // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
    assign pop  = out_vld && out_rdy && !flush;
    assign push = wr_en && (!full || pop) && !flush;
    assign drop = wr_en && full && !pop && !flush;
    // Storage is deliberately left unreset; the rst gate keeps the array untouched while held in reset.
    always_ff @(posedge clk)
        if (push && rst) mem[wr_ptr] <= wr_dat;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr   <= flush ? '0 : push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr   <= flush ? '0 : pop ? rd_ptr + 1'b1 : rd_ptr;
            level    <= flush ? '0 : (push && !pop) ? level + 1'b1 : (pop && !push) ? level - 1'b1 : level;
            overflow <= drop || (overflow && !ovf_clr);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo at DEPTH=16, DAT_W=9
module tb_uart_tx_fifo;
    logic       clk = 1'b0, rst = 1'b0, flush = 1'b0, wr_en = 1'b0, out_rdy = 1'b0, ovf_clr = 1'b0;
    logic [8:0] wr_dat = '0, out_dat;
    logic [4:0] af_thr = 5'd12, level;
    logic       out_vld, almost_full, full, empty, overflow;
    int         n_run = 0, n_fail = 0;
    logic [8:0] mq[$];
    logic [8:0] expv[$];

    uart_tx_fifo #(.DEPTH(16), .DAT_W(9)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_dat(wr_dat), .wr_en(wr_en),
        .out_dat(out_dat), .out_vld(out_vld), .out_rdy(out_rdy), .level(level),
        .af_thr(af_thr), .almost_full(almost_full), .full(full), .empty(empty),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [8:0] d);
        wr_en = 1'b1;
        wr_dat = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_vld", out_vld, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);
        step();
        rst = 1'b1;
        step();

        // fill with out_rdy=0
        for (int i = 0; i < 16; i++) begin
            wr(9'(i));
            chk("fill_level", level, i + 1);
            chk("fill_af", almost_full, (i + 1) >= 12);
            chk("fill_full", full, (i + 1) == 16);
            chk("fill_head", out_dat, 0);
        end

        // dropped write at full
        wr(9'h1AA);
        chk("ovf_level", level, 16);
        chk("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // simultaneous push and pop at full
        chk("sim_head", out_dat, 0);
        out_rdy = 1'b1;
        wr(9'h155);
        out_rdy = 1'b0;
        chk("sim_level", level, 16);
        chk("sim_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) expv.push_back(9'(i));
        expv.push_back(9'h155);
        out_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_vld", out_vld, 1);
            chk("drain_dat", out_dat, expv[i]);
            step();
        end
        out_rdy = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);

        // out_rdy ignored while empty
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        chk("empty_pop_level", level, 0);
        chk("empty_pop_vld", out_vld, 0);

        // set wins over clear
        for (int i = 0; i < 16; i++) wr(9'h0F0);
        ovf_clr = 1'b1;
        wr(9'h0AA);
        chk("setwin_ovf", overflow, 1);
        step();
        ovf_clr = 1'b0;
        chk("setwin_clr", overflow, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_full_level", level, 0);

        // wrap-around with random stalls against a queue model
        begin
            int pushed = 0, cyc = 0;
            bit pp, pu;
            while ((pushed < 40 || mq.size() > 0) && cyc < 2000) begin
                wr_en = (pushed < 40) && ($urandom_range(0, 3) != 0);
                wr_dat = 9'h100 + 9'(pushed);
                out_rdy = $urandom_range(0, 2) != 0;
                pp = (mq.size() > 0) && out_rdy;
                pu = wr_en && ((mq.size() < 16) || pp);
                step();
                if (pp) void'(mq.pop_front());
                if (pu) begin
                    mq.push_back(wr_dat);
                    pushed++;
                end
                chk("wrap_level", level, mq.size());
                chk("wrap_vld", out_vld, mq.size() > 0);
                if (mq.size() > 0) chk("wrap_dat", out_dat, mq[0]);
                cyc++;
            end
            wr_en = 1'b0;
            out_rdy = 1'b0;
            chk("wrap_done", cyc < 2000, 1);
        end

        // flush with concurrent write at level 5
        for (int i = 0; i < 5; i++) wr(9'h010 + 9'(i));
        chk("pre_flush_level", level, 5);
        flush = 1'b1;
        wr(9'h0EE);
        flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_empty", empty, 1);
        wr(9'h033);
        chk("post_flush_dat", out_dat, 9'h033);
        chk("post_flush_level", level, 1);

        // asynchronous reset mid-stream at level 7
        for (int i = 0; i < 6; i++) wr(9'h020 + 9'(i));
        chk("pre_rst_level", level, 7);
        out_rdy = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_mid_vld", out_vld, 0);
        chk("rst_mid_level", level, 0);
        out_rdy = 1'b0;
        step();
        rst = 1'b1;
        step();
        wr(9'h0AB);
        chk("post_rst_dat", out_dat, 9'h0AB);
        chk("post_rst_level", level, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
